// File: rtl/apb_reg_bank_pkg.sv
// Shared types and register map constants for the APB register bank.
// No logic; no latency.
// No flow control of its own.
package apb_reg_bank_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned IDX_STATUS     = 0;
    localparam int unsigned IDX_INT_STATUS = 1;
    localparam int unsigned IDX_INT_ENABLE = 2;

    // STATUS layout: constant-one marker, live irq, register count.
    localparam int unsigned STATUS_ONE_BIT   = 0;
    localparam int unsigned STATUS_IRQ_BIT   = 1;
    localparam int unsigned STATUS_NREGS_LSB = 8;
    localparam int unsigned STATUS_NREGS_W   = 8;

endpackage

// File: rtl/apb_reg_bank_decode.sv
// Address decode for the register bank: index, hit and error classification.
// Purely combinational, zero latency.
// No flow control; evaluated on the latched transfer attributes.
module apb_reg_bank_decode #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    input  logic                  priv,
    output logic [ADDR_WIDTH-3:0] idx,
    output logic                  hit,
    output logic                  err
);
    import apb_reg_bank_pkg::*;

    logic misaligned;
    logic out_of_range;
    logic ro_write;
    logic priv_fault;

    always_comb begin
        idx          = addr[ADDR_WIDTH-1:2];
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = (32'(idx) >= NUM_REGS);
        ro_write     = write && (32'(idx) == IDX_STATUS);
        // Unprivileged masters may still clear interrupts, nothing else.
        priv_fault   = write && !priv && (32'(idx) != IDX_INT_STATUS);
        err          = misaligned || out_of_range || ro_write || priv_fault;
        hit          = !err;
    end

endmodule

// File: rtl/apb_reg_bank.sv
// APB4 register bank with W1C interrupt status and level irq; APB_REG_PPROT_EN adds pprot checking.
// Latency: 2 + WAIT_STATES cycles from setup; irq lags status/enable by one cycle.
// Backpressure: pready held low for WAIT_STATES access cycles; psel drop in ACCESS aborts without write.
module apb_reg_bank #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    input  logic [DATA_WIDTH-1:0]   hw_event,
    output logic                    irq
`ifdef APB_REG_PPROT_EN
    ,
    input  logic [2:0]              pprot
`endif
);
    import apb_reg_bank_pkg::*;

    localparam int unsigned IW = ADDR_WIDTH - 2;
    localparam int unsigned NB = DATA_WIDTH / 8;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic                    priv_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;

    logic [IW-1:0]           idx;
    logic                    hit;
    logic                    err;
    logic                    priv_in;
    logic                    done;
    logic                    commit;

    logic [DATA_WIDTH-1:0]   int_status;
    logic [DATA_WIDTH-1:0]   int_enable;
    logic [DATA_WIDTH-1:0]   gp_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   wmask;
    logic [DATA_WIDTH-1:0]   w1c_mask;
    logic [DATA_WIDTH-1:0]   status_val;
    logic [DATA_WIDTH-1:0]   rdata;

`ifdef APB_REG_PPROT_EN
    logic unused_pprot;
    assign priv_in      = pprot[0];
    assign unused_pprot = ^pprot[2:1];
`else
    assign priv_in = 1'b1;
`endif

    apb_reg_bank_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_decode (
        .addr  (addr_q),
        .write (write_q),
        .priv  (priv_q),
        .idx   (idx),
        .hit   (hit),
        .err   (err)
    );

    // Completion also requires the master to still be in the access phase,
    // so an aborted transfer never raises pready.
    assign done    = (state == ACCESS) && (wait_cnt == 4'd0) && psel && penable;
    assign commit  = done && write_q && hit;
    assign pready  = done;
    assign pslverr = done && err;
    assign prdata  = (done && !write_q && hit) ? rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            priv_q   <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state    <= ACCESS;
                        wait_cnt <= 4'(WAIT_STATES);
                        addr_q   <= paddr;
                        write_q  <= pwrite;
                        priv_q   <= priv_in;
                        wdata_q  <= pwdata;
                        strb_q   <= pstrb;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (penable) begin
                        if (wait_cnt != 4'd0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        wmask = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            wmask[k*8 +: 8] = {8{strb_q[k]}};
        end
        w1c_mask = '0;
        if (commit && (32'(idx) == IDX_INT_STATUS)) begin
            w1c_mask = wdata_q & wmask;
        end
    end

    always_comb begin
        status_val                                      = '0;
        status_val[STATUS_ONE_BIT]                      = 1'b1;
        status_val[STATUS_IRQ_BIT]                      = irq;
        status_val[STATUS_NREGS_LSB +: STATUS_NREGS_W]  = 8'(NUM_REGS);

        rdata = '0;
        if (32'(idx) == IDX_STATUS) begin
            rdata = status_val;
        end else if (32'(idx) == IDX_INT_STATUS) begin
            rdata = int_status;
        end else if (32'(idx) == IDX_INT_ENABLE) begin
            rdata = int_enable;
        end else begin
            for (int unsigned i = 3; i < NUM_REGS; i++) begin
                if (32'(idx) == i) begin
                    rdata = gp_regs[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_status <= '0;
            int_enable <= '0;
            irq        <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                gp_regs[i] <= '0;
            end
        end else begin
            irq <= |(int_status & int_enable);
            // hw_event is OR'd in after the clear so a same-cycle set survives.
            int_status <= (int_status & ~w1c_mask) | hw_event;
            if (commit && (32'(idx) == IDX_INT_ENABLE)) begin
                int_enable <= (int_enable & ~wmask) | (wdata_q & wmask);
            end
            for (int unsigned i = 3; i < NUM_REGS; i++) begin
                if (commit && (32'(idx) == i)) begin
                    gp_regs[i] <= (gp_regs[i] & ~wmask) | (wdata_q & wmask);
                end
            end
        end
    end

endmodule
